// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage: EX->MEM pipeline register owning the Z/V/N flags, with stall/flush and sticky HLT freeze.
// Optional macro FLAG_BYPASS_EN exposes the commit-qualified next-state flags for same-cycle branch resolution.
module ex_mem_flag_stage #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic [3:0]            ex_opcode,
   input  logic [DATA_W-1:0]     ex_result,
   input  logic                  ex_ovfl,
   input  logic [DATA_W-1:0]     ex_store_data,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_wr,
   input  logic                  ex_mem_rd,
   input  logic                  ex_mem_wr,
   input  logic                  ex_hlt,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  mem_valid,
   output logic [3:0]            mem_opcode,
   output logic [DATA_W-1:0]     mem_result,
   output logic [DATA_W-1:0]     mem_store_data,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  mem_reg_wr,
   output logic                  mem_mem_rd,
   output logic                  mem_mem_wr,
   output logic                  mem_hlt,
   output logic                  flag_z,
   output logic                  flag_v,
   output logic                  flag_n,
   output logic                  halted
`ifdef FLAG_BYPASS_EN
   ,
   output logic                  flag_z_nxt,
   output logic                  flag_v_nxt,
   output logic                  flag_n_nxt
`endif
);
   typedef enum logic {RUN, HALTED} state_t;
   state_t state;
   logic commit, arith, z_only, z_d, v_d, n_d;
   // ADD/SUB set all flags; XOR and shifts/rotate set Z only; everything else leaves flags alone
   always_comb begin
      commit = (state == RUN) & ex_valid & ~stall & ~flush;
      arith  = commit & (ex_opcode[3:1] == 3'b000);
      z_only = commit & ((ex_opcode == 4'b0010) | ((ex_opcode[3:2] == 2'b01) & (ex_opcode != 4'b0111)));
      z_d    = (arith | z_only) ? (ex_result == '0) : flag_z;
      v_d    = arith ? ex_ovfl : flag_v;
      n_d    = arith ? ex_result[DATA_W-1] : flag_n;
   end
`ifdef FLAG_BYPASS_EN
   assign flag_z_nxt = z_d;
   assign flag_v_nxt = v_d;
   assign flag_n_nxt = n_d;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= RUN;
         mem_valid      <= 1'b0;
         mem_opcode     <= '0;
         mem_result     <= '0;
         mem_store_data <= '0;
         mem_rd         <= '0;
         mem_reg_wr     <= 1'b0;
         mem_mem_rd     <= 1'b0;
         mem_mem_wr     <= 1'b0;
         mem_hlt        <= 1'b0;
         flag_z         <= 1'b0;
         flag_v         <= 1'b0;
         flag_n         <= 1'b0;
         halted         <= 1'b0;
      end else if (state == RUN && !stall) begin
         mem_valid  <= commit;
         mem_reg_wr <= commit & ex_reg_wr;
         mem_mem_rd <= commit & ex_mem_rd;
         mem_mem_wr <= commit & ex_mem_wr;
         mem_hlt    <= commit & ex_hlt;
         if (commit) begin
            mem_opcode     <= ex_opcode;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
         end
         flag_z <= z_d;
         flag_v <= v_d;
         flag_n <= n_d;
         if (commit & ex_hlt) begin
            state  <= HALTED;
            halted <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// tb_ex_mem_flag_stage: vector table driven through a scoreboard queue, plus reset, halt and bypass sequences.
module tb_ex_mem_flag_stage;
   typedef struct packed {
      logic valid; logic [3:0] op; logic [15:0] res; logic ovfl; logic [15:0] sd; logic [3:0] rd;
      logic rw, mr, mw, hlt, stall, flush;
   } in_t;
   typedef struct packed {
      logic valid; logic [3:0] op; logic [15:0] res; logic [15:0] sd; logic [3:0] rd;
      logic rw, mr, mw, hlt, z, v, n, halted;
   } out_t;
   typedef struct packed { in_t i; out_t o; } vec_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic ex_valid, ex_ovfl, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_hlt, stall, flush;
   logic [3:0] ex_opcode, ex_rd, mem_opcode, mem_rd;
   logic [15:0] ex_result, ex_store_data, mem_result, mem_store_data;
   logic mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_hlt, flag_z, flag_v, flag_n, halted;
`ifdef FLAG_BYPASS_EN
   logic flag_z_nxt, flag_v_nxt, flag_n_nxt;
`endif
   int total = 0, bad = 0;
   vec_t vecs[22];
   out_t sb[$];

   ex_mem_flag_stage dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
      .ex_ovfl(ex_ovfl), .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_hlt(ex_hlt), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_result(mem_result),
      .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr),
      .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr), .mem_hlt(mem_hlt),
      .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .halted(halted)
`ifdef FLAG_BYPASS_EN
      , .flag_z_nxt(flag_z_nxt), .flag_v_nxt(flag_v_nxt), .flag_n_nxt(flag_n_nxt)
`endif
   );

   always #5 clk = ~clk;

   function automatic out_t sample();
      return out_t'{mem_valid, mem_opcode, mem_result, mem_store_data, mem_rd, mem_reg_wr,
                    mem_mem_rd, mem_mem_wr, mem_hlt, flag_z, flag_v, flag_n, halted};
   endfunction

   task automatic drive(input in_t x);
      {ex_valid, ex_opcode, ex_result, ex_ovfl, ex_store_data, ex_rd, ex_reg_wr, ex_mem_rd,
       ex_mem_wr, ex_hlt, stall, flush} = x;
   endtask

   // data fields of a bubble are don't-care, so only control, flags and halted are compared
   task automatic check_out(input string name, input out_t got, input out_t exp);
      out_t m;
      m = '1;
      if (!exp.valid) begin
         m.op = '0; m.res = '0; m.sd = '0; m.rd = '0;
      end
      total++;
      if (((got ^ exp) & m) != '0) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h mask=%h", name, got, exp, m);
      end
   endtask

   task automatic check_bits(input string name, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b expected=%b", name, got, exp);
      end
   endtask

   initial begin
      out_t e, r9, r18;
      r9  = '{1, 4'h9, 16'h0010, 16'hBEEF, 4'd0, 0, 0, 1, 0, 1, 1, 1, 0};
      r18 = '{1, 4'hF, 16'h0000, 16'h0000, 4'd0, 0, 0, 0, 1, 0, 0, 0, 1};
      //            valid op  res       ovfl sd        rd    rw mr mw hlt st fl
      vecs[0]  = '{'{1, 4'h0, 16'h0000, 1, 16'h1111, 4'd1, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h0, 16'h0000, 16'h1111, 4'd1, 1, 0, 0, 0, 1, 1, 0, 0}};
      vecs[1]  = '{'{1, 4'h1, 16'h8001, 0, 16'h2222, 4'd2, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h1, 16'h8001, 16'h2222, 4'd2, 1, 0, 0, 0, 0, 0, 1, 0}};
      vecs[2]  = '{'{1, 4'h0, 16'h8000, 1, 16'h3333, 4'd3, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h0, 16'h8000, 16'h3333, 4'd3, 1, 0, 0, 0, 0, 1, 1, 0}};
      vecs[3]  = '{'{1, 4'h2, 16'h0000, 0, 16'h0000, 4'd4, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h2, 16'h0000, 16'h0000, 4'd4, 1, 0, 0, 0, 1, 1, 1, 0}};
      vecs[4]  = '{'{1, 4'h3, 16'hFFF3, 0, 16'h0000, 4'd5, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h3, 16'hFFF3, 16'h0000, 4'd5, 1, 0, 0, 0, 1, 1, 1, 0}};
      vecs[5]  = '{'{1, 4'h2, 16'h0005, 0, 16'h0000, 4'd6, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h2, 16'h0005, 16'h0000, 4'd6, 1, 0, 0, 0, 0, 1, 1, 0}};
      vecs[6]  = '{'{1, 4'h4, 16'h0000, 0, 16'h0000, 4'd7, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h4, 16'h0000, 16'h0000, 4'd7, 1, 0, 0, 0, 1, 1, 1, 0}};
      vecs[7]  = '{'{1, 4'h7, 16'h0001, 0, 16'h0000, 4'd8, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h7, 16'h0001, 16'h0000, 4'd8, 1, 0, 0, 0, 1, 1, 1, 0}};
      vecs[8]  = '{'{1, 4'h8, 16'h0000, 0, 16'h0000, 4'd9, 1, 1, 0, 0, 0, 0},
                   '{1, 4'h8, 16'h0000, 16'h0000, 4'd9, 1, 1, 0, 0, 1, 1, 1, 0}};
      vecs[9]  = '{'{1, 4'h9, 16'h0010, 0, 16'hBEEF, 4'd0, 0, 0, 1, 0, 0, 0}, r9};
      vecs[10] = '{'{1, 4'h0, 16'h0001, 0, 16'h4444, 4'd1, 1, 0, 0, 0, 1, 1}, r9};
      vecs[11] = '{'{1, 4'h0, 16'h0001, 0, 16'h4444, 4'd1, 1, 0, 0, 0, 1, 1}, r9};
      vecs[12] = '{'{1, 4'h0, 16'h0001, 0, 16'h4444, 4'd1, 1, 0, 0, 0, 1, 1}, r9};
      vecs[13] = '{'{1, 4'h0, 16'h0001, 0, 16'h4444, 4'd1, 1, 0, 0, 0, 0, 1},
                   '{0, 4'h9, 16'h0010, 16'hBEEF, 4'd0, 0, 0, 0, 0, 1, 1, 1, 0}};
      vecs[14] = '{'{0, 4'h0, 16'h0001, 0, 16'h4444, 4'd1, 1, 0, 0, 0, 0, 0},
                   '{0, 4'h9, 16'h0010, 16'hBEEF, 4'd0, 0, 0, 0, 0, 1, 1, 1, 0}};
      vecs[15] = '{'{1, 4'h5, 16'h0001, 0, 16'h0000, 4'd10, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h5, 16'h0001, 16'h0000, 4'd10, 1, 0, 0, 0, 0, 1, 1, 0}};
      vecs[16] = '{'{1, 4'h6, 16'h0000, 0, 16'h0000, 4'd11, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h6, 16'h0000, 16'h0000, 4'd11, 1, 0, 0, 0, 1, 1, 1, 0}};
      vecs[17] = '{'{1, 4'h1, 16'h0001, 0, 16'h0000, 4'd12, 1, 0, 0, 0, 0, 0},
                   '{1, 4'h1, 16'h0001, 16'h0000, 4'd12, 1, 0, 0, 0, 0, 0, 0, 0}};
      vecs[18] = '{'{1, 4'hF, 16'h0000, 0, 16'h0000, 4'd0, 0, 0, 0, 1, 0, 0}, r18};
      vecs[19] = '{'{1, 4'h0, 16'h0000, 1, 16'h5555, 4'd13, 1, 0, 0, 0, 0, 0}, r18};
      vecs[20] = '{'{1, 4'h0, 16'h0000, 1, 16'h5555, 4'd13, 1, 0, 0, 0, 0, 1}, r18};
      vecs[21] = '{'{0, 4'h0, 16'h0000, 0, 16'h0000, 4'd0, 0, 0, 0, 0, 1, 0}, r18};

      drive('0);
      repeat (2) @(negedge clk);
      check_out("reset_state", sample(), '0);
      rst_n = 1'b1;
      for (int k = 0; k < 22; k++) begin
         @(negedge clk);
         drive(vecs[k].i);
         sb.push_back(vecs[k].o);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check_out($sformatf("vec%0d", k), sample(), e);
      end
      repeat (5) begin
         @(negedge clk);
         drive('{1, 4'h0, 16'h0000, 1, 16'h0000, 4'd0, 1, 0, 0, 0, 0, 0});
      end
      @(posedge clk);
      #1;
      check_bits("halt_sticky", {halted, mem_hlt, mem_opcode == 4'hF, flag_z}, 4'b1110);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_reset", sample(), '0);
      @(negedge clk);
      drive('0);
      rst_n = 1'b1;
      @(negedge clk);
      drive('{1, 4'h0, 16'h0000, 1, 16'h0000, 4'd1, 1, 0, 0, 0, 0, 0});
`ifdef FLAG_BYPASS_EN
      #1;
      check_bits("bypass_commit", {1'b0, flag_z_nxt, flag_v_nxt, flag_n_nxt}, 4'b0110);
      check_bits("bypass_reg_before", {1'b0, flag_z, flag_v, flag_n}, 4'b0000);
`endif
      @(posedge clk);
      #1;
      check_bits("flags_after_add", {1'b0, flag_z, flag_v, flag_n}, 4'b0110);
      @(negedge clk);
      drive('{1, 4'h1, 16'h8001, 0, 16'h0000, 4'd2, 1, 0, 0, 0, 1, 0});
`ifdef FLAG_BYPASS_EN
      #1;
      check_bits("bypass_stall", {1'b0, flag_z_nxt, flag_v_nxt, flag_n_nxt}, 4'b0110);
`endif
      @(posedge clk);
      #1;
      check_bits("flags_stall_hold", {1'b0, flag_z, flag_v, flag_n}, 4'b0110);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
